// File: rtl/bp_train_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_train_queue : in-flight branch record FIFO that pairs in-order
//                  resolutions with predictions and drives predictor training
// Revision 1.0
// ---------------------------------------------------------------------------
module bp_train_queue #(
  parameter int N     = 7,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [N-1:0]               pred_pc,
  input  logic [N-1:0]               pred_history,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       train_valid,
  output logic                       train_taken,
  output logic                       train_mispredicted,
  output logic [N-1:0]               train_history,
  output logic [N-1:0]               train_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [N-1:0]  hist_mem  [DEPTH];
  logic          taken_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          suppress;

  logic do_pop;
  logic mispredict_pop;
  logic discard;
  logic do_push;
  logic push_dropped;
  logic empty_resolve;

  assign pred_ready = (count != FULL_COUNT);

  always_comb begin
    do_pop         = resolve_valid && (count != '0) && !flush;
    mispredict_pop = do_pop && (resolve_taken != taken_mem[head]);
    // Wrong-path pushes are dropped silently while the predictor history
    // is unrepaired (the mispredict cycle and the one after it).
    discard        = flush || mispredict_pop || suppress;
    do_push        = pred_valid && pred_ready && !discard;
    push_dropped   = pred_valid && !pred_ready && !discard;
    empty_resolve  = resolve_valid && (count == '0) && !flush;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[tail]    <= pred_pc;
      hist_mem[tail]  <= pred_history;
      taken_mem[tail] <= pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      suppress           <= 1'b0;
      train_valid        <= 1'b0;
      train_taken        <= 1'b0;
      train_mispredicted <= 1'b0;
      train_history      <= '0;
      train_pc           <= '0;
      overflow           <= 1'b0;
      underflow          <= 1'b0;
    end else begin
      train_valid <= do_pop;
      overflow    <= push_dropped;
      underflow   <= empty_resolve;
      suppress    <= mispredict_pop;
      if (do_pop) begin
        train_taken        <= resolve_taken;
        train_mispredicted <= mispredict_pop;
        train_pc           <= pc_mem[head];
        train_history      <= hist_mem[head];
      end
      if (flush || mispredict_pop) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + AW'(1);
        if (do_pop)  head <= head + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_train_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bp_train_queue : directed + random bench checked against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_bp_train_queue;

  localparam int N     = 7;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_valid;
  logic [N-1:0]  pred_pc;
  logic [N-1:0]  pred_history;
  logic          pred_taken;
  logic          pred_ready;
  logic          resolve_valid;
  logic          resolve_taken;
  logic          flush;
  logic          train_valid;
  logic          train_taken;
  logic          train_mispredicted;
  logic [N-1:0]  train_history;
  logic [N-1:0]  train_pc;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  bp_train_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .pred_valid         (pred_valid),
    .pred_pc            (pred_pc),
    .pred_history       (pred_history),
    .pred_taken         (pred_taken),
    .pred_ready         (pred_ready),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .flush              (flush),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
    .train_pc           (train_pc),
    .count              (count),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] hist;
    logic         taken;
  } ent_t;

  ent_t         mq[$];
  bit           m_sup;
  logic         e_tv, e_tt, e_tm, e_ov, e_un;
  logic [N-1:0] e_tpc, e_th;
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",        32'(count),              32'(mq.size()));
    chk("pred_ready",   32'(pred_ready),         32'(mq.size() != DEPTH));
    chk("train_valid",  32'(train_valid),        32'(e_tv));
    chk("train_taken",  32'(train_taken),        32'(e_tt));
    chk("train_misp",   32'(train_mispredicted), 32'(e_tm));
    chk("train_pc",     32'(train_pc),           32'(e_tpc));
    chk("train_hist",   32'(train_history),      32'(e_th));
    chk("overflow",     32'(overflow),           32'(e_ov));
    chk("underflow",    32'(underflow),          32'(e_un));
  endtask

  task automatic idle_inputs();
    pred_valid = 0; pred_pc = '0; pred_history = '0; pred_taken = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
  endtask

  // Reset with arbitrary activity on the other inputs; reset must win.
  task automatic do_reset(input bit busy);
    reset = 1;
    if (busy) begin
      pred_valid = 1; pred_pc = N'($urandom); pred_history = N'($urandom);
      pred_taken = 1'($urandom); resolve_valid = 1; resolve_taken = 1'($urandom);
    end
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    mq.delete(); m_sup = 0;
    e_tv = 0; e_tt = 0; e_tm = 0; e_ov = 0; e_un = 0; e_tpc = '0; e_th = '0;
    check_all();
  endtask

  // One clock: drive inputs, advance the reference model, compare after the edge.
  task automatic cyc(input bit pv, input int ppc, input int ph, input bit pt,
                     input bit rv, input bit rt, input bit fl);
    bit   pop, misp, disc, acc;
    ent_t e;
    pred_valid = pv; pred_pc = N'(ppc); pred_history = N'(ph); pred_taken = pt;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    pop  = rv && (mq.size() != 0) && !fl;
    misp = 0;
    if (pop) misp = (rt != mq[0].taken);
    disc = fl || misp || m_sup;
    acc  = pv && (mq.size() != DEPTH) && !disc;
    e_tv = pop;
    e_ov = pv && (mq.size() == DEPTH) && !disc;
    e_un = rv && (mq.size() == 0) && !fl;
    if (pop) begin
      e_tt = rt; e_tm = misp; e_tpc = mq[0].pc; e_th = mq[0].hist;
    end
    m_sup = misp;
    if (fl || misp) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e.pc = N'(ppc); e.hist = N'(ph); e.taken = pt;
        mq.push_back(e);
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset(0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Fill, then one push too many
    for (int i = 0; i < 8; i++) cyc(1, 'h10 + i, i, (i % 2) == 0, 0, 0, 0);
    cyc(1, 'h18, 8, 1, 0, 0, 0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Three correctly predicted resolves from full
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("res0_pc", 32'(train_pc), 32'h10);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("res2_pc", 32'(train_pc), 32'h12);
    chk("res_count", 32'(count), 32'd5);

    // Mispredict flushes younger entries and suppresses the next push
    do_reset(0);
    cyc(1, 'h20, 'h35, 1, 0, 0, 0);
    cyc(1, 'h21, 'h36, 0, 0, 0, 0);
    cyc(1, 'h22, 'h37, 1, 0, 0, 0);
    cyc(1, 'h23, 'h38, 1, 1, 0, 0);
    chk("misp_pc", 32'(train_pc), 32'h20);
    chk("misp_flag", 32'(train_mispredicted), 32'd1);
    chk("misp_hist", 32'(train_history), 32'h35);
    cyc(1, 'h24, 'h39, 0, 0, 0, 0);
    cyc(1, 'h25, 'h3a, 1, 0, 0, 0);
    chk("misp_after", 32'(count), 32'd1);

    // Underflow, then flush beating concurrent resolve and push
    do_reset(0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("unf_pulse", 32'(underflow), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 'h30 + i, i, 1, 0, 0, 0);
    cyc(1, 'h34, 4, 1, 1, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Pointer wrap-around with one entry in flight
    for (int i = 0; i < 20; i++) begin
      cyc(1, 'h40 + i, 'h7f - i, i[0], 0, 0, 0);
      cyc(0, 0, 0, 0, 1, i[0], 0);
      chk("wrap_pc", 32'(train_pc), 32'('h40 + i));
    end

    // Random traffic, including a mid-operation reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      cyc($urandom_range(0, 99) < 60, int'($urandom_range(0, 127)),
          int'($urandom_range(0, 127)), 1'($urandom),
          $urandom_range(0, 99) < 40, 1'($urandom_range(0, 99) < 70),
          $urandom_range(0, 99) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_train_queue.md
Name: bp_train_queue

Overview:
- In-flight branch tracking queue that sits directly downstream of the gshare predictor and directly upstream of its training port.
- Records each prediction (pc, history, predicted direction) in program order.
- Pairs each in-order branch resolution with the oldest record and produces the predictor's train_* signals one cycle later.
- On a misprediction, flushes all younger (wrong-path) records.

Parameters:
- N, 7, pc/history width (matches predictor index width)
- DEPTH, 8, number of in-flight entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pred_valid  in  1  predictor issued a prediction this cycle
- pred_pc  in  N  pc of the predicted branch
- pred_history  in  N  global history used for the prediction
- pred_taken  in  1  predicted direction
- pred_ready  out  1  queue can accept a push (count != DEPTH)
- resolve_valid  in  1  oldest in-flight branch resolved this cycle
- resolve_taken  in  1  actual direction
- flush  in  1  external pipeline flush (exception/redirect)
- train_valid  out  1  registered train strobe to predictor
- train_taken  out  1  actual direction
- train_mispredicted  out  1  actual != predicted
- train_history  out  N  stored history of the resolved entry
- train_pc  out  N  stored pc of the resolved entry
- count  out  clog2(DEPTH+1)  current occupancy
- overflow  out  1  one-cycle pulse: push attempted while full
- underflow  out  1  one-cycle pulse: resolve while empty

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, history, taken}; head/tail pointers wrap modulo DEPTH; count is explicit, 0..DEPTH.
- Reset (synchronous): count=0, pointers=0, suppress=0, and all outputs 0 (train_* all 0, overflow=0, underflow=0). pred_ready=1 after reset.
- Push (accepted) when pred_valid && pred_ready && !discard, where discard = flush || mispredict_pop || suppress.
  - Entry is written at tail; tail advances.
- pred_valid && !pred_ready && !discard: push dropped, state unchanged, overflow=1 next cycle.
- Pop when resolve_valid && count!=0 && !flush:
  - Head is read; registered next cycle: train_valid=1, train_taken=resolve_taken, train_mispredicted=(resolve_taken != head.taken), train_pc=head.pc, train_history=head.history.
  - Latency: exactly 1 cycle from resolve to train_valid.
- resolve_valid && count==0 && !flush: ignored, underflow=1 next cycle, train_valid=0.
- Correct-direction pop with simultaneous push: both occur, count unchanged. pred_ready is purely !full, so a full queue rejects a push even in a cycle with a pop.
- Mispredicted pop:
  - Head is emitted as above.
  - All remaining entries are discarded: count=0, head=tail=0 next cycle.
  - A push in the same cycle is discarded without an overflow pulse.
  - The suppress register is set to 1 for the following cycle, i.e. the cycle train_valid&&train_mispredicted is visible, while the predictor history is still unrepaired. Pushes in that cycle are also discarded silently. suppress then clears.
- flush=1:
  - Queue cleared next cycle (count=0, pointers 0).
  - Concurrent resolve and push are ignored; no train_valid, no underflow/overflow.
  - flush has priority over all other events.
- train_valid, overflow and underflow are single-cycle pulses, 0 when there is no event.
- train_* data outputs hold their last values when train_valid=0.
- count and pred_ready reflect registered state (pred_ready combinational from count only).
- Reset asserted mid-operation: takes effect at the next edge regardless of other inputs; all in-flight entries are lost.

Test Plan:
- Reset then idle -> count=0, pred_ready=1, train_valid=0, overflow=underflow=0.
- Push 8 entries (pc=0x10..0x17, history=0x00..0x07, taken alternating 1,0,...), then a 9th push -> count=8, pred_ready=0, overflow pulses once, count stays 8.
- From full, resolve 3 with matching directions (1,0,1) -> train_valid on 3 consecutive cycles one cycle after each resolve, train_pc=0x10,0x11,0x12, train_mispredicted=0, count=5.
- Queue holds pc 0x20 (pred taken=1), 0x21, 0x22. Resolve with resolve_taken=0 while pushing pc 0x23, then push pc 0x24 next cycle, then pc 0x25 -> train_pc=0x20, train_mispredicted=1, train_history=stored value; 0x23 and 0x24 discarded; 0x25 accepted, count=1.
- Resolve on empty queue -> underflow=1 for one cycle, train_valid=0, count=0. Then flush with 4 entries while resolve_valid and pred_valid are both high -> count=0, no train_valid, no pulses.
- Wrap-around: 20 interleaved push/pop pairs with resolve matching prediction -> pointers wrap, train_pc sequence equals push order, count never exceeds 1.
